// File: rtl/ctrl_serial_wb_if.sv
// Bus bundle for ctrl_serial_wb.
// Groups the Wishbone master signals and the byte rx/tx channels.
//   master : the controller side. It drives the Wishbone request and the tx byte.
//   slave  : the environment side (peripheral interconnect plus byte front-end).
// Wishbone: cyc/stb/we/adr/dat out, dat_i/ack in.
// rx: rx_data_i/rx_stb_i in.  tx: tx_data_o/tx_stb_o out, tx_rdy_i in.
interface ctrl_serial_wb_if #(
  parameter int ADR_W = 16,
  parameter int DAT_W = 32
);
  logic             wb_cyc_o;
  logic             wb_stb_o;
  logic             wb_we_o;
  logic [ADR_W-1:0] wb_adr_o;
  logic [DAT_W-1:0] wb_dat_o;
  logic [DAT_W-1:0] wb_dat_i;
  logic             wb_ack_i;
  logic [7:0]       rx_data_i;
  logic             rx_stb_i;
  logic [7:0]       tx_data_o;
  logic             tx_stb_o;
  logic             tx_rdy_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i,
    input  rx_data_i, rx_stb_i,
    output tx_data_o, tx_stb_o,
    input  tx_rdy_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i,
    output rx_data_i, rx_stb_i,
    input  tx_data_o, tx_stb_o,
    output tx_rdy_i
  );
endinterface

// File: rtl/ctrl_serial_wb.sv
// ctrl_serial_wb: byte-stream to Wishbone B4 classic bus controller.
// Frame: CMD (bit7 = write), then ADR_W/8 address bytes MSB first, then
// DAT_W/8 data bytes MSB first (writes only). Each frame runs one bus cycle.
// The response is streamed on tx: the read data MSB first, 0x01 for a
// write, or 0xFF when the bus times out.
// Ports: clk_i, rst_i (async, active-high), bus (ctrl_serial_wb_if.master).
// Optional macro CTRL_SERIAL_WB_TIMEOUT_EN enables the TIMEOUT bus watchdog.
module ctrl_serial_wb #(
  parameter int ADR_W   = 16,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  ctrl_serial_wb_if.master   bus
);
  localparam int NA    = ADR_W / 8;
  localparam int ND    = DAT_W / 8;
  localparam int NMAX  = (NA > ND) ? NA : ND;
  localparam int CNT_W = (NMAX > 1) ? $clog2(NMAX) : 1;

  typedef enum logic [2:0] {IDLE, ADR, DAT, BUS, RESP} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               we_q;
  logic               cyc_q;
  logic [ADR_W-1:0]   adr_q;
  logic [DAT_W-1:0]   dat_q;
  logic [DAT_W-1:0]   resp_q;
  logic               single_q;   // response is a single status byte
  logic [7:0]         tx_data_q;
  logic               tx_stb_q;

  // Shift the incoming byte in at the LSB end. The full-width temporaries
  // keep this legal when a field is just one byte wide.
  logic [ADR_W+7:0]   adr_cat;
  logic [DAT_W+7:0]   dat_cat;
  logic [DAT_W-1:0]   resp_sh;
  assign adr_cat = {adr_q, bus.rx_data_i};
  assign dat_cat = {dat_q, bus.rx_data_i};
  assign resp_sh = resp_q << 8;

  logic to_hit;
`ifdef CTRL_SERIAL_WB_TIMEOUT_EN
  // The counter sits at zero outside BUS, so it is cleared on BUS entry.
  // A hit means this is the TIMEOUT-th BUS cycle without an ack.
  logic [15:0] to_cnt_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                          to_cnt_q <= '0;
    else if (state_q != BUS)            to_cnt_q <= '0;
    else if (!bus.wb_ack_i)             to_cnt_q <= to_cnt_q + 16'd1;
  end
  assign to_hit = (state_q == BUS) && (to_cnt_q == 16'(TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      resp_q    <= '0;
      single_q  <= 1'b0;
      tx_data_q <= 8'h00;
      tx_stb_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.rx_stb_i) begin
          we_q    <= bus.rx_data_i[7];
          cnt_q   <= '0;
          state_q <= ADR;
        end
        ADR: if (bus.rx_stb_i) begin
          adr_q <= adr_cat[ADR_W-1:0];
          if (cnt_q == CNT_W'(NA - 1)) begin
            cnt_q <= '0;
            if (we_q) state_q <= DAT;
            else begin
              state_q <= BUS;
              cyc_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DAT: if (bus.rx_stb_i) begin
          dat_q <= dat_cat[DAT_W-1:0];
          if (cnt_q == CNT_W'(ND - 1)) begin
            cnt_q   <= '0;
            state_q <= BUS;
            cyc_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        BUS: begin
          // Stb equals cyc and is high throughout BUS, so gating the ack by
          // the state covers the "sample only while stb" rule. When an ack
          // and the timeout land on the same cycle, the ack wins.
          if (bus.wb_ack_i) begin
            cyc_q    <= 1'b0;
            state_q  <= RESP;
            tx_stb_q <= 1'b1;
            cnt_q    <= '0;
            if (we_q) begin
              single_q  <= 1'b1;
              tx_data_q <= 8'h01;
            end else begin
              single_q  <= 1'b0;
              resp_q    <= bus.wb_dat_i;
              tx_data_q <= bus.wb_dat_i[DAT_W-1 -: 8];
            end
          end else if (to_hit) begin
            cyc_q     <= 1'b0;
            state_q   <= RESP;
            tx_stb_q  <= 1'b1;
            single_q  <= 1'b1;
            tx_data_q <= 8'hFF;
          end
        end
        RESP: if (bus.tx_rdy_i) begin
          if (single_q || cnt_q == CNT_W'(ND - 1)) begin
            tx_stb_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            cnt_q     <= cnt_q + CNT_W'(1);
            resp_q    <= resp_sh;
            tx_data_q <= resp_sh[DAT_W-1 -: 8];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.wb_cyc_o  = cyc_q;
  assign bus.wb_stb_o  = cyc_q;
  assign bus.wb_we_o   = we_q;
  assign bus.wb_adr_o  = adr_q;
  assign bus.wb_dat_o  = dat_q;
  assign bus.tx_data_o = tx_data_q;
  assign bus.tx_stb_o  = tx_stb_q;
endmodule

// File: tb/tb_ctrl_serial_wb.sv
module tb_ctrl_serial_wb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  ctrl_serial_wb_if #(.ADR_W(16), .DAT_W(32)) bus ();

  ctrl_serial_wb #(.ADR_W(16), .DAT_W(32), .TIMEOUT(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data_i = b;
    bus.rx_stb_i  = 1'b1;
    @(negedge clk);
    bus.rx_stb_i  = 1'b0;
  endtask

  // Ack after 'waits' cycles of bus wait. Returns at the negedge after the ack edge.
  task automatic do_ack(input int waits, input logic [31:0] d);
    repeat (waits) @(negedge clk);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = d;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
  endtask

  // Accept one tx byte after 'hold' cycles with rdy low. ok=0 on a wait
  // timeout; stable=0 if the byte moved or stb dropped while held.
  task automatic recv(input int hold, output logic [7:0] b, output bit ok, output bit stable);
    int n = 0;
    ok = 1'b1; stable = 1'b1; b = 8'h00;
    while (!bus.tx_stb_o && n < 50) begin @(negedge clk); n++; end
    if (!bus.tx_stb_o) begin ok = 1'b0; return; end
    b = bus.tx_data_o;
    repeat (hold) begin
      bus.tx_rdy_i = 1'b0;
      @(negedge clk);
      if (bus.tx_data_o !== b || bus.tx_stb_o !== 1'b1) stable = 1'b0;
    end
    bus.tx_rdy_i = 1'b1;
    @(negedge clk);
    bus.tx_rdy_i = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.tx_stb_o} !== 4'b0 ||
        bus.wb_adr_o !== 16'h0 || bus.wb_dat_o !== 32'h0 || bus.tx_data_o !== 8'h0)
      $display("FAIL reset_state: cyc=%b stb=%b we=%b adr=%h dat=%h tx=%h/%b, need all zero",
               bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o,
               bus.tx_data_o, bus.tx_stb_o);
    else passes++;
    // A stray ack in IDLE must not start anything.
    do_ack(0, 32'h12345678);
    checks++;
    if (bus.wb_cyc_o !== 1'b0 || bus.tx_stb_o !== 1'b0)
      $display("FAIL stray_ack: cyc=%b tx_stb=%b, need 0/0", bus.wb_cyc_o, bus.tx_stb_o);
    else passes++;
  endtask

  task automatic test_read;
    logic [7:0] b; bit ok, st;
    logic [31:0] exp = 32'hDEADBEEF;
    send_byte(8'h00); send_byte(8'h12);
    checks++;
    if (bus.wb_cyc_o !== 1'b0) $display("FAIL read_cyc_early: cyc=%b, need 0", bus.wb_cyc_o);
    else passes++;
    send_byte(8'h34);
    checks++;
    if (bus.wb_cyc_o !== 1'b1 || bus.wb_stb_o !== 1'b1 || bus.wb_adr_o !== 16'h1234 || bus.wb_we_o !== 1'b0)
      $display("FAIL read_bus: cyc=%b stb=%b adr=%h we=%b, need 1 1 1234 0",
               bus.wb_cyc_o, bus.wb_stb_o, bus.wb_adr_o, bus.wb_we_o);
    else passes++;
    do_ack(2, exp);
    checks++;
    if (bus.wb_cyc_o !== 1'b0 || bus.tx_stb_o !== 1'b1)
      $display("FAIL read_ack_edge: cyc=%b tx_stb=%b, need 0/1", bus.wb_cyc_o, bus.tx_stb_o);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      recv(0, b, ok, st);
      checks++;
      if (!ok || b !== exp[31-8*i -: 8])
        $display("FAIL read_byte%0d: got %h (ok=%b), need %h", i, b, ok, exp[31-8*i -: 8]);
      else passes++;
    end
    checks++;
    if (bus.tx_stb_o !== 1'b0) $display("FAIL read_end: tx_stb=%b, need 0", bus.tx_stb_o);
    else passes++;
  endtask

  task automatic test_write;
    logic [7:0] b; bit ok, st;
    send_byte(8'h80); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA);
    checks++;
    if (bus.wb_cyc_o !== 1'b0) $display("FAIL write_cyc_early: cyc=%b, need 0", bus.wb_cyc_o);
    else passes++;
    send_byte(8'hBE);
    checks++;
    if (bus.wb_cyc_o !== 1'b1 || bus.wb_we_o !== 1'b1 || bus.wb_adr_o !== 16'h0005 || bus.wb_dat_o !== 32'hCAFEBABE)
      $display("FAIL write_bus: cyc=%b we=%b adr=%h dat=%h, need 1 1 0005 cafebabe",
               bus.wb_cyc_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o);
    else passes++;
    do_ack(0, 32'h0);
    recv(0, b, ok, st);
    checks++;
    if (!ok || b !== 8'h01) $display("FAIL write_resp: got %h (ok=%b), need 01", b, ok);
    else passes++;
    checks++;
    if (bus.tx_stb_o !== 1'b0) $display("FAIL write_end: tx_stb=%b, need 0", bus.tx_stb_o);
    else passes++;
  endtask

  task automatic test_backpressure;
    logic [7:0] b; bit ok, st;
    logic [31:0] exp = 32'h01234567;
    send_byte(8'h00); send_byte(8'hBE); send_byte(8'hEF);
    do_ack(0, exp);
    for (int i = 0; i < 4; i++) begin
      recv(5, b, ok, st);
      checks++;
      if (!ok || !st || b !== exp[31-8*i -: 8])
        $display("FAIL bp_byte%0d: got %h ok=%b stable=%b, need %h stable", i, b, ok, st, exp[31-8*i -: 8]);
      else passes++;
    end
    checks++;
    if (bus.tx_stb_o !== 1'b0) $display("FAIL bp_end: tx_stb=%b, need 0", bus.tx_stb_o);
    else passes++;
  endtask

  task automatic test_drop;
    logic [7:0] b; bit ok, st;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h42);
    send_byte(8'h80);  // arrives in BUS and must vanish
    checks++;
    if (bus.wb_cyc_o !== 1'b1 || bus.wb_adr_o !== 16'h0042)
      $display("FAIL drop_bus: cyc=%b adr=%h, need 1 0042", bus.wb_cyc_o, bus.wb_adr_o);
    else passes++;
    do_ack(0, 32'hA5000000);
    for (int i = 0; i < 4; i++) recv(0, b, ok, st);
    // If the dropped byte had opened a frame, this read would be misparsed.
    send_byte(8'h00); send_byte(8'h77); send_byte(8'h66);
    checks++;
    if (bus.wb_cyc_o !== 1'b1 || bus.wb_we_o !== 1'b0 || bus.wb_adr_o !== 16'h7766)
      $display("FAIL drop_next: cyc=%b we=%b adr=%h, need 1 0 7766", bus.wb_cyc_o, bus.wb_we_o, bus.wb_adr_o);
    else passes++;
    do_ack(0, 32'h0);
    for (int i = 0; i < 4; i++) recv(0, b, ok, st);
  endtask

  task automatic test_reset_mid;
    logic [7:0] b; bit ok, st;
    logic [31:0] exp = 32'h11223344;
    // Reset while in BUS: cyc drops without waiting for a clock edge.
    send_byte(8'h00); send_byte(8'h12); send_byte(8'h34);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0)
      $display("FAIL rst_bus: cyc=%b stb=%b, need 0/0", bus.wb_cyc_o, bus.wb_stb_o);
    else passes++;
    @(negedge clk); rst = 1'b0;
    // Reset mid-ADR: the partial frame is discarded.
    send_byte(8'h00); send_byte(8'hAB);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.tx_stb_o} !== 4'b0 ||
        bus.wb_adr_o !== 16'h0 || bus.wb_dat_o !== 32'h0 || bus.tx_data_o !== 8'h0)
      $display("FAIL rst_adr: cyc=%b we=%b adr=%h dat=%h tx=%h/%b, need all zero",
               bus.wb_cyc_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o, bus.tx_data_o, bus.tx_stb_o);
    else passes++;
    @(negedge clk); rst = 1'b0;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    checks++;
    if (bus.wb_cyc_o !== 1'b1 || bus.wb_adr_o !== 16'h0001)
      $display("FAIL rst_next: cyc=%b adr=%h, need 1 0001", bus.wb_cyc_o, bus.wb_adr_o);
    else passes++;
    do_ack(1, exp);
    for (int i = 0; i < 4; i++) begin
      recv(0, b, ok, st);
      checks++;
      if (!ok || b !== exp[31-8*i -: 8])
        $display("FAIL rst_byte%0d: got %h (ok=%b), need %h", i, b, ok, exp[31-8*i -: 8]);
      else passes++;
    end
  endtask

  task automatic test_timeout;
    logic [7:0] b; bit ok, st;
    int n;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
`ifdef CTRL_SERIAL_WB_TIMEOUT_EN
    n = 0;
    while (bus.wb_cyc_o && n < 100) begin n++; @(negedge clk); end
    checks++;
    if (n != 8) $display("FAIL to_cycles: cyc high %0d cycles, need 8", n);
    else passes++;
    recv(0, b, ok, st);
    checks++;
    if (!ok || b !== 8'hFF) $display("FAIL to_resp: got %h (ok=%b), need ff", b, ok);
    else passes++;
    send_byte(8'h80); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h09);
    do_ack(0, 32'h0);
    recv(0, b, ok, st);
    checks++;
    if (!ok || b !== 8'h01 || bus.wb_dat_o !== 32'h9)
      $display("FAIL to_after: got %h dat=%h (ok=%b), need 01 00000009", b, bus.wb_dat_o, ok);
    else passes++;
`else
    // Without the watchdog the bus waits for the ack however long it takes.
    repeat (20) @(negedge clk);
    checks++;
    if (bus.wb_cyc_o !== 1'b1 || bus.tx_stb_o !== 1'b0)
      $display("FAIL no_to_wait: cyc=%b tx_stb=%b, need 1/0", bus.wb_cyc_o, bus.tx_stb_o);
    else passes++;
    do_ack(0, 32'hFF000000);
    recv(0, b, ok, st);
    checks++;
    if (!ok || b !== 8'hFF) $display("FAIL no_to_resp: got %h (ok=%b), need ff", b, ok);
    else passes++;
    n = 0;
    for (int i = 1; i < 4; i++) begin recv(0, b, ok, st); if (ok && b === 8'h00) n++; end
    checks++;
    if (n != 3) $display("FAIL no_to_tail: %0d zero bytes, need 3", n);
    else passes++;
`endif
  endtask

  initial begin
    bus.wb_dat_i  = '0;
    bus.wb_ack_i  = 1'b0;
    bus.rx_data_i = 8'h00;
    bus.rx_stb_i  = 1'b0;
    bus.tx_rdy_i  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_read;
    test_write;
    test_backpressure;
    test_drop;
    test_reset_mid;
    test_timeout;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
